// File: rtl/reg_file_sb.sv
// Multi-read-port integer register file with a per-register write-pending
// scoreboard; reads are combinational with optional same-cycle write bypass.

module reg_file_sb_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                             active,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             wr,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]                 pending,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             busy
);

  localparam bit ZR  = (ZERO_REG != 0);
  localparam bit BYP = (BYPASS != 0);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!active || (ZR && addr == '0)) begin
      data = '0;
      busy = 1'b0;
    end else if (BYP && wr && waddr == addr) begin
      // writeback retires the producer this cycle, so the reader need not stall
      data = wdata;
      busy = 1'b0;
    end else begin
      data = regs[addr];
      busy = pending[addr];
    end
  end

endmodule

module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           WRITE_EN,
  input  logic [ADDR_WIDTH-1:0]          INADDRESS,
  input  logic [DATA_WIDTH-1:0]          IN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] RD_ADDR,
  output logic [NUM_READ*DATA_WIDTH-1:0] RD_DATA,
  output logic [NUM_READ-1:0]            RD_BUSY,
  input  logic                           ISSUE_EN,
  input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDR,
  input  logic                           FLUSH,
  output logic [ADDR_WIDTH:0]            PENDING_CNT
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 pending, pending_nxt;
  logic [ADDR_WIDTH:0]              cnt, cnt_nxt;
  logic                             wr, is, set_new, clr_old;

  // Reset gates the strobes too, so bypass cannot leak data while RESET is low.
  assign wr = RESET && WRITE_EN && !(ZR && INADDRESS == '0);
  assign is = RESET && ISSUE_EN && !FLUSH && !(ZR && ISSUE_ADDR == '0);

  assign set_new = is && !pending[ISSUE_ADDR];
  assign clr_old = wr && pending[INADDRESS] && !(is && ISSUE_ADDR == INADDRESS);

  always_comb begin
    pending_nxt = pending;
    cnt_nxt     = cnt;
    if (FLUSH) begin
      pending_nxt = '0;
      cnt_nxt     = '0;
    end else begin
      // clear before set: a new producer on the written register supersedes it
      if (wr) pending_nxt[INADDRESS] = 1'b0;
      if (is) pending_nxt[ISSUE_ADDR] = 1'b1;
      cnt_nxt = cnt + (ADDR_WIDTH+1)'(set_new) - (ADDR_WIDTH+1)'(clr_old);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      regs    <= '0;
      pending <= '0;
      cnt     <= '0;
    end else begin
      if (wr) regs[INADDRESS] <= IN;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign PENDING_CNT = cnt;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    reg_file_sb_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS),
      .DEPTH      (DEPTH)
    ) u_port (
      .active  (RESET),
      .addr    (RD_ADDR[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr      (wr),
      .waddr   (INADDRESS),
      .wdata   (IN),
      .regs    (regs),
      .pending (pending),
      .data    (RD_DATA[k*DATA_WIDTH +: DATA_WIDTH]),
      .busy    (RD_BUSY[k])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Drives two reg_file_sb builds (default with bypass, and a 64-bit/16-entry/
// 3-port build without bypass) in lockstep against an array-based model.

module tb_reg_file_sb;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_n, write_en, issue_en, flush;
  logic [4:0]  inaddr, issue_addr;
  logic [63:0] in_data;
  logic [4:0]  ra [3];

  logic [63:0]  a_rd_data;
  logic [1:0]   a_busy;
  logic [5:0]   a_cnt;
  logic [191:0] b_rd_data;
  logic [2:0]   b_busy;
  logic [4:0]   b_cnt;

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .CLK(CLK), .RESET(rst_n), .WRITE_EN(write_en), .INADDRESS(inaddr), .IN(in_data[31:0]),
    .RD_ADDR({ra[1], ra[0]}), .RD_DATA(a_rd_data), .RD_BUSY(a_busy),
    .ISSUE_EN(issue_en), .ISSUE_ADDR(issue_addr), .FLUSH(flush), .PENDING_CNT(a_cnt));

  reg_file_sb #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .CLK(CLK), .RESET(rst_n), .WRITE_EN(write_en), .INADDRESS(inaddr[3:0]), .IN(in_data),
    .RD_ADDR({ra[2][3:0], ra[1][3:0], ra[0][3:0]}), .RD_DATA(b_rd_data), .RD_BUSY(b_busy),
    .ISSUE_EN(issue_en), .ISSUE_ADDR(issue_addr[3:0]), .FLUSH(flush), .PENDING_CNT(b_cnt));

  // model: index 0 = dut_a, index 1 = dut_b
  logic [63:0] m_reg [2][32];
  bit          m_pend [2][32];
  int vectors = 0;
  int miscompares = 0;

  function automatic int amask(int d);
    return (d == 0) ? 31 : 15;
  endfunction

  function automatic logic [63:0] dmask(int d);
    return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_data(int d, logic [4:0] a_in);
    int a  = int'(a_in) & amask(d);
    int wa = int'(inaddr) & amask(d);
    if (!rst_n || a == 0) return 64'd0;
    if (d == 0 && write_en && wa == a) return in_data & dmask(d);
    return m_reg[d][a];
  endfunction

  function automatic logic exp_busy(int d, logic [4:0] a_in);
    int a  = int'(a_in) & amask(d);
    int wa = int'(inaddr) & amask(d);
    if (!rst_n || a == 0) return 1'b0;
    if (d == 0 && write_en && wa == a) return 1'b0;
    return m_pend[d][a];
  endfunction

  function automatic int exp_cnt(int d);
    int n = 0;
    for (int i = 0; i <= amask(d); i++) n += int'(m_pend[d][i]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("a.p%0d.data a=%0d", k, ra[k]), {32'd0, a_rd_data[k*32 +: 32]}, exp_data(0, ra[k]));
      chk($sformatf("a.p%0d.busy a=%0d", k, ra[k]), 64'(a_busy[k]), 64'(exp_busy(0, ra[k])));
    end
    chk("a.cnt", 64'(a_cnt), 64'(exp_cnt(0)));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b.p%0d.data a=%0d", k, ra[k]), b_rd_data[k*64 +: 64], exp_data(1, ra[k]));
      chk($sformatf("b.p%0d.busy a=%0d", k, ra[k]), 64'(b_busy[k]), 64'(exp_busy(1, ra[k])));
    end
    chk("b.cnt", 64'(b_cnt), 64'(exp_cnt(1)));
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 32; i++) begin
        m_reg[d][i]  = '0;
        m_pend[d][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int wa = int'(inaddr) & amask(d);
      int ia = int'(issue_addr) & amask(d);
      if (write_en && wa != 0) m_reg[d][wa] = in_data & dmask(d);
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[d][i] = 1'b0;
      end else begin
        if (write_en && wa != 0) m_pend[d][wa] = 1'b0;
        if (issue_en && ia != 0) m_pend[d][ia] = 1'b1;
      end
    end
  endtask

  // inputs are driven just after a rising edge; check mid-cycle, then advance
  task automatic step();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [63:0] v);
    write_en = 1'b1; inaddr = a; in_data = v;
  endtask

  task automatic do_issue(input logic [4:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  task automatic reads(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; idle(); inaddr = '0; issue_addr = '0; in_data = '0;
    reads(0, 0, 0);
    model_reset();
    step(); step();
    rst_n = 1'b1;

    // reset mid-run discards x5 even while a write is being presented
    do_write(5, 64'hDEAD_BEEF); reads(5, 5, 5); step();
    idle(); step();
    do_write(5, 64'hDEAD_BEEF);
    reset_pulse();
    idle(); step();

    // zero register ignores write and issue
    do_write(0, 64'h1234); do_issue(0); reads(0, 0, 0); step();
    idle(); step();

    // write with same-cycle read: bypass on dut_a, old value on dut_b
    do_write(7, 64'hA5A5_A5A5_A5A5_A5A5); reads(3, 7, 7); step();
    idle(); step();

    // scoreboard lifecycle
    reads(3, 4, 3);
    do_issue(3); step();
    do_issue(4); step();
    idle(); step();
    do_write(3, 64'h33); step();
    idle(); step();

    // simultaneous issue and write: same register, then different registers
    reads(9, 12, 9);
    do_issue(9); step();
    do_write(9, 64'h99); do_issue(9); step();
    idle(); step();
    do_write(9, 64'h98); do_issue(12); step();
    idle(); step();

    // flush beats same-cycle issue; same-cycle write still lands
    foreach (ra[i]) ra[i] = 5'(i + 1);
    for (int i = 0; i < 5; i++) begin do_issue(5'(i + 1)); step(); end
    idle(); step();
    flush = 1'b1; do_issue(10); do_write(11, 64'h77); reads(10, 11, 1); step();
    idle(); step();

    // fill every non-zero register: dut_a reaches 31, dut_b 15
    for (int i = 1; i < 32; i++) begin do_issue(5'(i)); reads(5'(i), 5'(i - 1), 5'(i)); step(); end
    idle(); step();
    do_issue(15); step();
    idle(); step();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      write_en   = ($urandom_range(0, 2) != 0);
      inaddr     = 5'($urandom);
      in_data    = {$urandom(), $urandom()};
      issue_en   = ($urandom_range(0, 2) != 0);
      issue_addr = 5'($urandom);
      flush      = ($urandom_range(0, 24) == 0);
      foreach (ra[i]) ra[i] = ($urandom_range(0, 3) == 0) ? inaddr : 5'($urandom);
      if ($urandom_range(0, 149) == 0) reset_pulse();
      else step();
    end
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with a per-register write-pending scoreboard, used by the RV32IM pipeline's decode stage. It holds the architectural integer registers and provides NUM_READ combinational read ports with optional same-cycle write-to-read bypass. It also tracks which registers have an in-flight producer, so hazard logic can stall on RD_BUSY instead of comparing pipeline-stage addresses.

## Interface

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of read ports; legal values are 1 to 4.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1, when 1, read ports forward the same-cycle write data.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WRITE_EN  in  1  writeback strobe.
- INADDRESS  in  ADDR_WIDTH  writeback address.
- IN  in  DATA_WIDTH  writeback data.
- RD_ADDR  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- RD_DATA  out  NUM_READ*DATA_WIDTH  packed read data, same packing as RD_ADDR.
- RD_BUSY  out  NUM_READ  port k's register has a pending producer.
- ISSUE_EN  in  1  marks ISSUE_ADDR as pending; asserted when an instruction that writes a register issues.
- ISSUE_ADDR  in  ADDR_WIDTH  destination register of the issuing instruction.
- FLUSH  in  1  synchronous clear of all pending bits (pipeline flush).
- PENDING_CNT  out  ADDR_WIDTH+1  number of registers currently pending.

## Operation

State:
- REGISTERS[DEPTH]: DEPTH registers of DATA_WIDTH bits.
- PENDING[DEPTH]: one pending bit per register.
- PENDING_CNT register.

Effective write and issue:
- Effective write (wr) = WRITE_EN && !(ZERO_REG && INADDRESS == 0).
- Effective issue (is) = ISSUE_EN && !FLUSH && !(ZERO_REG && ISSUE_ADDR == 0).

Data write:
- On the rising edge, if wr, REGISTERS[INADDRESS] <= IN.
- Data writes proceed normally during FLUSH.

Read port k, combinational:
- If ZERO_REG and the address is 0: RD_DATA = 0 and RD_BUSY = 0.
- Else if BYPASS and wr and INADDRESS equals the port address: RD_DATA = IN and RD_BUSY = 0. The data is valid this cycle.
- Else: RD_DATA = REGISTERS[addr] and RD_BUSY = PENDING[addr].

Scoreboard update on each rising edge, in priority order:
- FLUSH: PENDING <= 0 and PENDING_CNT <= 0. The same-cycle issue is dropped; the same-cycle write still updates data.
- Otherwise, wr clears PENDING[INADDRESS], then is sets PENDING[ISSUE_ADDR].
  - If both target the same address, set wins: the bit stays 1 because a new producer supersedes the old one.
- PENDING_CNT <= PENDING_CNT + set_new - clr_old.
  - set_new = is && !PENDING[ISSUE_ADDR].
  - clr_old = wr && PENDING[INADDRESS] && !(is && ISSUE_ADDR == INADDRESS).
  - The counter never wraps. Its range is 0 to DEPTH (0 to DEPTH-1 when ZERO_REG=1).
- A write to a non-pending register is legal: data updates and the scoreboard is unchanged.
- Re-issuing an already-pending address leaves its bit and the count unchanged.

Reset:
- While RESET is low, all REGISTERS, PENDING and PENDING_CNT are 0 immediately and asynchronously.
- Writes, issues and bypass are suppressed, so RD_DATA is 0, RD_BUSY is 0 and PENDING_CNT is 0.
- Reset asserted mid-operation discards all state. The first edge after release acts normally.

## Timing

- Read latency is 0 cycles: RD_DATA and RD_BUSY are combinational from RD_ADDR, state and same-cycle write and issue inputs.
- Write latency is 1 cycle. Without BYPASS, a read of INADDRESS returns the new value in the cycle after the WRITE_EN edge.
- An issue at edge N makes RD_BUSY high from after edge N until the edge where the matching wr is sampled.
  - With BYPASS, RD_BUSY already drops in the writeback cycle itself.
- FLUSH takes effect at the edge where it is sampled. RD_BUSY is 0 on all ports in the following cycle.
- PENDING_CNT is registered and always equals the popcount of PENDING after each edge.
- Each read port is independent. All ports may address the same register.

## Test plan

- **Reset and zero register:** pulse RESET low mid-run after writing x5=0xDEADBEEF -> RD_DATA=0 and PENDING_CNT=0 during and after reset. Then write x0=0x1234 and issue x0 -> reading x0 gives 0, RD_BUSY=0, PENDING_CNT=0.
- **Write/read and bypass:** write x7=0xA5A5A5A5 with RD_ADDR port1=7 in the same cycle. BYPASS=1 -> port1=0xA5A5A5A5 that cycle. BYPASS=0 -> old value 0 that cycle and 0xA5A5A5A5 next cycle.
- **Scoreboard lifecycle:** issue x3, then x4 -> PENDING_CNT=2 and RD_BUSY high for ports reading 3 and 4. Write x3 -> port reading 3 is not busy and PENDING_CNT=1.
- **Simultaneous issue and write to the same register:** x9 pending, then wr x9 and issue x9 in the same edge -> RD_BUSY for x9 stays 1 and PENDING_CNT is unchanged. Repeat with different addresses -> the count is unchanged but the bits move.
- **Flush priority:** set 5 pending, then in one edge FLUSH=1, issue x10 and write x11=0x77 -> PENDING_CNT=0, all RD_BUSY=0, x10 is not pending and x11 reads 0x77.
- **Parameter sweep:** run with NUM_READ=3, DATA_WIDTH=64, ADDR_WIDTH=4. Fill all 15 non-zero registers pending -> PENDING_CNT=15. Random write, issue and read traffic is checked against a reference model.
